// File: rtl/rv32i_pkg.sv
// RV32I shared definitions: ALU operation selector used by the shared ALU and its arbiter.
package rv32i_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } ALUSel_e;

endpackage

// File: rtl/alu_arb_if.sv
// Bundle of request, shared-ALU and response signals around alu_arb.
// The slave modport is the arbiter; the master modport is its environment.
interface alu_arb_if #(
  parameter int TAG_W = 4
);
  import rv32i_pkg::*;

  logic [1:0]             i_req_valid;
  logic [1:0]             o_req_ready;
  logic [1:0][31:0]       i_req_operand_a;
  logic [1:0][31:0]       i_req_operand_b;
  ALUSel_e [1:0]          i_req_op;
  logic [1:0][TAG_W-1:0]  i_req_tag;

  logic [31:0]            o_alu_operand_a;
  logic [31:0]            o_alu_operand_b;
  ALUSel_e                o_alu_op;
  logic [31:0]            i_alu_res;

  logic                   o_rsp_valid;
  logic                   o_rsp_id;
  logic [TAG_W-1:0]       o_rsp_tag;
  logic [31:0]            o_rsp_res;
  logic                   i_rsp_ready;

  modport slave (
    input  i_req_valid, i_req_operand_a, i_req_operand_b, i_req_op, i_req_tag,
    input  i_alu_res, i_rsp_ready,
    output o_req_ready, o_alu_operand_a, o_alu_operand_b, o_alu_op,
    output o_rsp_valid, o_rsp_id, o_rsp_tag, o_rsp_res
  );

  modport master (
    output i_req_valid, i_req_operand_a, i_req_operand_b, i_req_op, i_req_tag,
    output i_alu_res, i_rsp_ready,
    input  o_req_ready, o_alu_operand_a, o_alu_operand_b, o_alu_op,
    input  o_rsp_valid, o_rsp_id, o_rsp_tag, o_rsp_res
  );
endinterface

// File: rtl/alu_arb.sv
// Two-requester arbiter for a shared combinational ALU with a one-entry response register.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arb
  import rv32i_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  alu_arb_if.slave  bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} rsp_state_e;

  rsp_state_e        state, state_nxt;
  logic [1:0]        grant;
  logic              gnt_id;
  logic              slot_free;
  logic              xfer;
  logic [1:0]        req_ready;
  logic [31:0]       rsp_res;
  logic              rsp_id;
  logic [TAG_W-1:0]  rsp_tag;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic prio;
`endif

  // Arbitration: a lone requester always wins; a tie is broken by prio or fixed order.
  always_comb begin
    grant = bus.i_req_valid;
    if (&bus.i_req_valid) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      grant = prio ? 2'b10 : 2'b01;
`else
      grant = 2'b01;
`endif
    end
    gnt_id    = grant[1];
    slot_free = (state == EMPTY) | bus.i_rsp_ready;
    req_ready = i_rst_n ? (grant & {2{slot_free}}) : 2'b00;
    xfer      = |req_ready;
  end

  always_comb begin
    bus.o_alu_operand_a = '0;
    bus.o_alu_operand_b = '0;
    bus.o_alu_op        = ALU_ADD;
    if (|grant) begin
      bus.o_alu_operand_a = bus.i_req_operand_a[gnt_id];
      bus.o_alu_operand_b = bus.i_req_operand_b[gnt_id];
      bus.o_alu_op        = bus.i_req_op[gnt_id];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (xfer) state_nxt = FULL;
      FULL:    if (!xfer && bus.i_rsp_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Response register stage: captures the ALU result on every transfer edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_res <= '0;
      rsp_id  <= 1'b0;
      rsp_tag <= '0;
    end else if (xfer) begin
      rsp_res <= bus.i_alu_res;
      rsp_id  <= gnt_id;
      rsp_tag <= bus.i_req_tag[gnt_id];
    end
  end

`ifdef ALU_ARB_ROUND_ROBIN_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prio <= 1'b0;
    end else if (xfer) begin
      prio <= ~gnt_id;
    end
  end
`endif

  assign bus.o_req_ready = req_ready;
  assign bus.o_rsp_valid = (state == FULL);
  assign bus.o_rsp_res   = rsp_res;
  assign bus.o_rsp_id    = rsp_id;
  assign bus.o_rsp_tag   = rsp_tag;

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter TAG_W, default 4: width of the per-request tag that is echoed with each response.
REQ-002 i_clk  input  1  clock; all state updates on the rising edge.
REQ-003 i_rst_n  input  1  reset; asynchronous, active-low.
REQ-004 i_req_valid  input  2  request valid; bit k belongs to requester k.
REQ-005 o_req_ready  output  2  request accept; requester k transfers when i_req_valid[k] & o_req_ready[k].
REQ-006 i_req_operand_a  input  2x32  operand A for each requester.
REQ-007 i_req_operand_b  input  2x32  operand B for each requester.
REQ-008 i_req_op  input  2xALUSel_e  ALU operation for each requester; ALUSel_e comes from rv32i_pkg.
REQ-009 i_req_tag  input  2xTAG_W  opaque tag for each requester.
REQ-010 o_alu_operand_a  output  32  operand A driven to the shared ALU.
REQ-011 o_alu_operand_b  output  32  operand B driven to the shared ALU.
REQ-012 o_alu_op  output  ALUSel_e  operation driven to the shared ALU.
REQ-013 i_alu_res  input  32  combinational result returned by the shared ALU.
REQ-014 o_rsp_valid  output  1  response register holds a result.
REQ-015 o_rsp_id  output  1  index of the requester that owns the response.
REQ-016 o_rsp_tag  output  TAG_W  tag of the owning request.
REQ-017 o_rsp_res  output  32  registered ALU result.
REQ-018 i_rsp_ready  input  1  consumer accepts the response.

Function
REQ-019 The block SHALL grant at most one requester per cycle, and only a requester whose i_req_valid bit is set.
REQ-020 slot_free SHALL be defined as !o_rsp_valid | i_rsp_ready; o_req_ready[k] SHALL equal grant[k] & slot_free.
REQ-021 o_alu_operand_a/b and o_alu_op SHALL carry the granted requester's fields combinationally; with no grant they SHALL be 0, 0 and ALU_ADD.
REQ-022 On a transfer edge the block SHALL register i_alu_res, the requester index and the tag into o_rsp_res/o_rsp_id/o_rsp_tag; o_rsp_valid SHALL rise on the following cycle, giving 1-cycle latency.
REQ-023 While o_rsp_valid & !i_rsp_ready, all o_rsp_* outputs SHALL hold stable and o_req_ready SHALL be 2'b00.
REQ-024 The response FSM SHALL have two states. EMPTY->FULL on a transfer. FULL->EMPTY on i_rsp_ready with no transfer. FULL->FULL when i_rsp_ready and a transfer occur in the same cycle; the new result overwrites the old one, sustaining 1 result per cycle.
REQ-025 Round-robin: a pointer prio selects the winner when both requesters are valid. After each transfer, prio SHALL become the index not granted. prio SHALL NOT change on cycles without a transfer, so a stalled grant stays on the same requester.
REQ-026 A single valid requester SHALL be granted regardless of prio.
REQ-027 A requester dropping i_req_valid before transfer SHALL cause no state change.

Reset
REQ-028 Reset assertion SHALL asynchronously clear o_rsp_valid, o_rsp_res, o_rsp_tag and o_rsp_id to 0, set the FSM to EMPTY and set prio to 0.
REQ-029 While i_rst_n=0, o_req_ready SHALL be 2'b00; a pending response SHALL be discarded when reset asserts mid-operation.
REQ-030 The first transfer SHALL be possible on the first rising edge after i_rst_n deasserts.

Configuration
REQ-031 With macro ALU_ARB_ROUND_ROBIN_EN defined, arbitration SHALL follow REQ-025.
REQ-032 With ALU_ARB_ROUND_ROBIN_EN undefined, requester 0 SHALL always win when both are valid, and the prio register SHALL NOT be implemented.

Verification
REQ-033 Req0 only: ADD a=5, b=7, tag=3, i_rsp_ready=1 -> next cycle o_rsp_valid=1, res=12, id=0, tag=3.
REQ-034 Both requesters valid continuously, i_rsp_ready=1, round-robin build -> grants alternate 0,1,0,1; one response per cycle. Fixed-priority build -> requester 0 is granted every cycle.
REQ-035 Response held with i_rsp_ready=0 for 3 cycles -> o_req_ready=00, o_rsp_* stable; when i_rsp_ready=1, a new accept occurs in that same cycle.
REQ-036 Req1 SUB a=3, b=5 followed by req0 SLTU a=1, b=0xFFFFFFFF -> responses 0xFFFFFFFE (id=1), then 1 (id=0).
REQ-037 i_rst_n pulsed low while o_rsp_valid=1 -> o_rsp_valid=0 immediately (no clock edge needed), prio=0, and the next grant after reset obeys REQ-026.
